// File: rtl/pipeline_pkg.sv
// Shared pipeline widths, NOP encoding and fetch FSM state type.
package pipeline_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam int PC_STEP = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic {RUN, HALT} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory bus: fetch stage is master (address out), memory is slave.
interface instruction_fetch_stage_if;
  import pipeline_pkg::*;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instruction;

  modport master (output imem_addr, input imem_instruction);
  modport slave  (input imem_addr, output imem_instruction);
endinterface

// File: rtl/instruction_fetch_stage_pc_register.sv
// PC register: next-PC select plus branch-target and end-of-memory checks.
module pc_register
  import pipeline_pkg::*;
#(
  parameter int                IMEM_BYTES = 64,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_en,
  input  logic              adv_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              target_bad,
  output logic              end_of_mem
);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_BYTES - PC_STEP);

  logic [ADDR_W-1:0] pc_nxt;

  assign pc_plus4   = pc + ADDR_W'(PC_STEP);
  assign target_bad = (branch_target[1:0] != 2'b00) || (branch_target > LAST_PC);
  assign end_of_mem = pc_plus4 > LAST_PC;

  // A bad target or the end of memory freezes the PC where it is.
  always_comb begin
    pc_nxt = pc;
    if (br_en) begin
      if (!target_bad) pc_nxt = branch_target;
    end else if (adv_en) begin
      if (!end_of_mem) pc_nxt = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_nxt;
  end
endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC, IF/ID register and RUN/HALT FSM.
// Optional FETCH_STATS_EN adds saturating fetch_count / bubble_count ports.
module instruction_fetch_stage
  import pipeline_pkg::*;
#(
  parameter int                IMEM_BYTES = 64,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'd0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_stage_if.master  imem,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [ADDR_W-1:0]          branch_target,
  output logic [INSTR_W-1:0]         if_id_instruction,
  output logic [ADDR_W-1:0]          if_id_pc_plus4,
  output logic                       if_id_valid,
  output logic                       halted,
  output logic                       fetch_error
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                fetch_count,
  output logic [31:0]                bubble_count
`endif
);
  fetch_state_t      state;
  logic [ADDR_W-1:0] pc, pc_plus4;
  logic              target_bad, end_of_mem;
  logic              br_en, adv_en;

  assign br_en  = (state == RUN) && branch_taken;
  assign adv_en = (state == RUN) && !branch_taken && !stall;

  pc_register #(.IMEM_BYTES(IMEM_BYTES), .RESET_PC(RESET_PC)) u_pc (
    .clk          (clk),
    .rst_n        (rst_n),
    .br_en        (br_en),
    .adv_en       (adv_en),
    .branch_target(branch_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .target_bad   (target_bad),
    .end_of_mem   (end_of_mem)
  );

  assign imem.imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= RUN;
      if_id_instruction <= NOP_INSTR;
      if_id_pc_plus4    <= '0;
      if_id_valid       <= 1'b0;
      halted            <= 1'b0;
      fetch_error       <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_INSTR;
            if (target_bad) begin
              state       <= HALT;
              halted      <= 1'b1;
              fetch_error <= 1'b1;
            end
          end else if (!stall) begin
            // Last word of memory is still delivered on the edge that halts.
            if_id_instruction <= imem.imem_instruction;
            if_id_pc_plus4    <= pc_plus4;
            if_id_valid       <= 1'b1;
            if (end_of_mem) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        HALT: begin
          if (!stall) begin
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_INSTR;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic fetch_inc, bubble_inc;
  assign fetch_inc  = adv_en;
  assign bubble_inc = br_en || ((state == HALT) && !stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (fetch_inc  && (fetch_count  != '1)) fetch_count  <= fetch_count + 32'd1;
      if (bubble_inc && (bubble_count != '1)) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed vector table, corner sequences,
// then random stimulus checked against a behavioural model.
module tb_instruction_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] if_id_instruction, if_id_pc_plus4;
  logic        if_id_valid, halted, fetch_error;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [16];

  instruction_fetch_stage_if bus();
  assign bus.imem_instruction = (bus.imem_addr < 32'd64) ? mem[bus.imem_addr[5:2]] : 32'hDEAD_BEEF;

  instruction_fetch_stage #(.IMEM_BYTES(64), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus.master), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_instruction(if_id_instruction), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_error(fetch_error)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // pc4 is only meaningful while IF/ID holds a real instruction
  task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] ins,
                         input logic [31:0] p4, input logic v, input logic h, input logic e);
    chk({tag, ".addr"},   bus.imem_addr, a);
    chk({tag, ".instr"},  if_id_instruction, ins);
    if (v) chk({tag, ".pc4"}, if_id_pc_plus4, p4);
    chk({tag, ".valid"},  {31'b0, if_id_valid}, {31'b0, v});
    chk({tag, ".halted"}, {31'b0, halted}, {31'b0, h});
    chk({tag, ".err"},    {31'b0, fetch_error}, {31'b0, e});
  endtask

  task automatic step(input logic st, input logic br, input logic [31:0] tgt);
    stall = st; branch_taken = br; branch_target = tgt;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic st, br; logic [31:0] tgt;
    logic [31:0] addr, instr, pc4; logic v, h, e;
  } vec_t;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_v, m_h, m_e;

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_v = 0; m_h = 0; m_e = 0;
  endtask

  task automatic model_step(input logic st, input logic br, input logic [31:0] tgt);
    if (!m_h) begin
      if (br) begin
        m_v = 0; m_instr = 0;
        if ((tgt % 4) != 0 || tgt > 60) begin m_h = 1; m_e = 1; end
        else m_pc = tgt;
      end else if (!st) begin
        m_instr = mem[m_pc / 4]; m_pc4 = m_pc + 4; m_v = 1;
        if (m_pc + 4 > 60) m_h = 1; else m_pc = m_pc + 4;
      end
    end else if (!st) begin
      m_v = 0; m_instr = 0;
    end
  endtask

  vec_t vecs[13];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 | i;

    vecs[0]  = '{0,0,0,  4,  32'hA0000000, 4,  1,0,0};
    vecs[1]  = '{0,0,0,  8,  32'hA0000001, 8,  1,0,0};
    vecs[2]  = '{1,0,0,  8,  32'hA0000001, 8,  1,0,0};
    vecs[3]  = '{1,0,0,  8,  32'hA0000001, 8,  1,0,0};
    vecs[4]  = '{0,0,0,  12, 32'hA0000002, 12, 1,0,0};
    vecs[5]  = '{0,0,0,  16, 32'hA0000003, 16, 1,0,0};
    vecs[6]  = '{0,1,0,  0,  32'h0,        0,  0,0,0};
    vecs[7]  = '{0,0,0,  4,  32'hA0000000, 4,  1,0,0};
    vecs[8]  = '{1,1,8,  8,  32'h0,        0,  0,0,0};
    vecs[9]  = '{0,0,0,  12, 32'hA0000002, 12, 1,0,0};
    vecs[10] = '{0,1,6,  12, 32'h0,        0,  0,1,1};
    vecs[11] = '{0,0,0,  12, 32'h0,        0,  0,1,1};
    vecs[12] = '{1,0,0,  12, 32'h0,        0,  0,1,1};

    #12 rst_n = 1'b1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.pc4", if_id_pc_plus4, 0);

    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].br, vecs[i].tgt);
      chk_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].pc4,
              vecs[i].v, vecs[i].h, vecs[i].e);
    end

    do_reset(); #1;
    chk_all("rst_after_err", 0, 0, 0, 0, 0, 0);

    // Out-of-range target of exactly IMEM_BYTES
    step(0, 0, 0);
    step(0, 1, 64);
    chk_all("oor64", 4, 0, 0, 0, 1, 1);
    step(0, 0, 0);
    chk_all("oor64_after", 4, 0, 0, 0, 1, 1);
    do_reset(); #1;

    // Run off the end of memory
    for (int i = 0; i < 15; i++) step(0, 0, 0);
    chk_all("pre_end", 60, 32'hA000000E, 60, 1, 0, 0);
    step(0, 0, 0);
    chk_all("end_word", 60, 32'hA000000F, 64, 1, 1, 0);
    step(0, 0, 0);
    chk_all("end_bubble", 60, 0, 0, 0, 1, 0);
    step(0, 1, 8);
    chk_all("halt_ignores_br", 60, 0, 0, 0, 1, 0);
    #2 rst_n = 1'b0; #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    chk("async_rst.pc4", if_id_pc_plus4, 0);
    #1 rst_n = 1'b1;

    // Random phase
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    @(posedge clk); #1;
    do_reset();
    model_reset();
    for (int n = 0; n < 500; n++) begin
      logic st, br; logic [31:0] tgt;
      if (m_h && ($urandom_range(0, 3) == 0)) begin
        do_reset(); model_reset();
      end
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 5) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 79)) : 32'($urandom_range(0, 15) * 4);
      model_step(st, br, tgt);
      step(st, br, tgt);
      chk_all($sformatf("rnd%0d", n), m_pc, m_instr, m_pc4, m_v, m_h, m_e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
